// File: rtl/hc_bist_pkg.sv
// Shared types and constants for the pin BIST: FSM states, MISR polynomial, LFSR taps.
package hc_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDrain,
        StCheck
    } bist_state_e;

    localparam logic [15:0] MisrPoly = 16'h1021;
    // Taps b7, b5, b4 and b3 feed the new bit 0.
    localparam logic [7:0]  LfsrTaps = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LfsrTaps)};
    endfunction

endpackage

// File: rtl/hc_pin_bist_if.sv
// Signal bundle between the pin BIST and its controller/observer.
interface hc_pin_bist_if;

    logic        ena;
    logic        start;
    logic [15:0] exp_sig;
    logic [7:0]  dut_out;
    logic [7:0]  dut_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;

    modport master (
        output ena, start, exp_sig, dut_out,
        input  dut_in, busy, done, pass, sig
    );

    modport slave (
        input  ena, start, exp_sig, dut_out,
        output dut_in, busy, done, pass, sig
    );

endinterface

// File: rtl/hc_misr16.sv
// 16-bit multiple-input signature register compacting an 8-bit response per enabled cycle.
module hc_misr16
    import hc_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] sig
);

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = 16'h0000;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MisrPoly : 16'h0000) ^ {8'h00, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/hc_pin_bist.sv
// Pin BIST: drives N_VEC LFSR vectors, compacts LAT-delayed responses into a MISR and
// reports done/pass against a golden signature.
module hc_pin_bist
    import hc_bist_pkg::*;
#(
    parameter int unsigned N_VEC = 64,
    parameter int unsigned LAT   = 1,
    parameter logic [7:0]  SEED  = 8'h01
) (
    input logic          clk,
    input logic          rst_n,
    hc_pin_bist_if.slave bus
);

    localparam logic [7:0]  SeedEff  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] VecLast  = 16'(N_VEC - 1);
    localparam logic [16:0] CapFirst = 17'(LAT);
    localparam logic [16:0] CapLast  = 17'(LAT + N_VEC - 1);

    bist_state_e state_q, state_d;
    logic [15:0] vec_q, vec_d;
    logic [16:0] cyc_q, cyc_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic        busy;
    logic [7:0]  dut_in;
    logic        capture;
    logic        cap_open;
    logic        run_start;
    logic [15:0] misr_sig;

    // Capture window opens once LAT cycles of the run have elapsed.
    assign cap_open  = (cyc_q > CapFirst) || (cyc_q == CapFirst);
    assign run_start = bus.ena && bus.start && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ena) begin
            unique case (state_q)
                StIdle:  if (bus.start) state_d = StDrive;
                StDrive: if (vec_q == VecLast) state_d = (LAT == 0) ? StCheck : StDrain;
                StDrain: if (cyc_q == CapLast) state_d = StCheck;
                StCheck: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b1;
        dut_in  = 8'h00;
        capture = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StDrive: begin
                dut_in  = lfsr_q;
                capture = cap_open;
            end
            StDrain: capture = cap_open;
            StCheck: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        vec_d  = vec_q;
        cyc_d  = cyc_q;
        lfsr_d = lfsr_q;
        done_d = done_q;
        pass_d = pass_q;
        if (bus.ena) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        vec_d  = 16'h0000;
                        cyc_d  = 17'h0_0000;
                        lfsr_d = SeedEff;
                        done_d = 1'b0;
                        pass_d = 1'b0;
                    end
                end
                StDrive: begin
                    lfsr_d = lfsr_next(lfsr_q);
                    cyc_d  = cyc_q + 17'd1;
                    // Saturate so the count never wraps inside a run.
                    if (vec_q != VecLast) vec_d = vec_q + 16'd1;
                end
                StDrain: cyc_d = cyc_q + 17'd1;
                StCheck: begin
                    done_d = 1'b1;
                    pass_d = (misr_sig == bus.exp_sig);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= 16'h0000;
            cyc_q  <= 17'h0_0000;
            lfsr_q <= SeedEff;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cyc_q  <= cyc_d;
            lfsr_q <= lfsr_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    hc_misr16 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .en    (bus.ena && capture),
        .din   (bus.dut_out),
        .sig   (misr_sig)
    );

    assign bus.dut_in = dut_in;
    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.pass   = pass_q;
    assign bus.sig    = misr_sig;

endmodule

// File: doc/hc_pin_bist.md
HC_PIN_BIST -- requirements
Module: hc_pin_bist

Interface
REQ-001 Parameter N_VEC, default 64: number of stimulus vectors per run, range 1..65535.
REQ-002 Parameter LAT, default 1: DUT response latency in clock cycles, range 0..7.
REQ-003 Parameter SEED, default 8'h01: LFSR start value; a value of 0 SHALL be replaced by 8'h01.
REQ-004 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  design-selected qualifier; when low, all state SHALL hold.
REQ-007 start  input  1  run request, sampled on a clk edge.
REQ-008 exp_sig  input  16  golden signature compared at the end of a run.
REQ-009 dut_out  input  8  DUT response (the user project's uo_out).
REQ-010 dut_in  output  8  stimulus driven to the DUT (the user project's ui_in).
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  level; high after a run completes, until the next run starts.
REQ-013 pass  output  1  qualified by done; high when the signature matched.
REQ-014 sig  output  16  current MISR value.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, DRAIN and CHECK; every transition SHALL require ena=1.
REQ-016 IDLE with start=1 -> DRIVE; the same edge SHALL load the LFSR with SEED, clear sig, vector count and cycle count, and clear done and pass.
REQ-017 start SHALL be ignored in DRIVE, DRAIN and CHECK; start in IDLE with done=1 SHALL begin a new run.
REQ-018 dut_in SHALL equal the LFSR value in DRIVE and 8'h00 in IDLE, DRAIN and CHECK.
REQ-019 LFSR: 8-bit Fibonacci, shift left, bit0_new = b7^b5^b4^b3, advancing once per DRIVE cycle; the sequence from 8'h01 SHALL be 01,02,04,08,11,...
REQ-020 DRIVE SHALL last exactly N_VEC cycles, then go to DRAIN for LAT cycles; with LAT=0, DRIVE SHALL go directly to CHECK.
REQ-021 Take cycle 0 as the first DRIVE cycle. The MISR SHALL capture dut_out on the edge ending cycle c, for c = LAT .. LAT+N_VEC-1 inclusive; this is exactly N_VEC captures.
REQ-022 MISR update: sig_next = (sig<<1) ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {8'h00, dut_out}, using 16-bit wrap-around arithmetic.
REQ-023 CHECK SHALL last one cycle; on the edge leaving CHECK, the block SHALL set done=1 and pass=(sig==exp_sig), then return to IDLE.
REQ-024 From the edge that samples start to the edge that sets done SHALL be N_VEC+LAT+1 cycles.
REQ-025 busy SHALL be 1 in DRIVE, DRAIN and CHECK, and 0 in IDLE.
REQ-026 When ena=0 mid-run, the FSM, counters, LFSR and MISR SHALL freeze, no capture SHALL occur, and dut_in SHALL hold its value.
REQ-027 The vector counter SHALL be 16 bits wide and SHALL NOT wrap within a run.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state=IDLE, dut_in=8'h00, busy=0, done=0, pass=0, sig=16'h0000, counters=0, LFSR=SEED.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release SHALL begin a clean run.

Structure
REQ-030 Package hc_bist_pkg SHALL hold the FSM state enum, the MISR polynomial constant 16'h1021 and the LFSR tap mask.
REQ-031 The MISR SHALL be a sub-module, hc_misr16, with ports clk, rst_n, clr, en, din[7:0] and sig[15:0].

Verification
REQ-032 N_VEC=4, LAT=0, start pulse -> dut_in = 01,02,04,08 over 4 cycles, then 00; done=1 at 5 cycles after the start edge.
REQ-033 N_VEC=1, LAT=0, dut_out=8'h5A, exp_sig=16'h005A -> sig=16'h005A, pass=1.
REQ-034 N_VEC=2, LAT=0, dut_out=8'h5A, exp_sig=16'h00EE -> pass=1; with exp_sig=16'h00EF -> pass=0.
REQ-035 N_VEC=64, LAT=1, dut_out tied to 8'h00, exp_sig=16'h0000 -> pass=1, busy high for 66 cycles.
REQ-036 ena dropped for 3 cycles mid-DRIVE -> dut_in and sig hold; the run completes at the same signature, 3 cycles later than an undisturbed run.
REQ-037 rst_n pulsed low mid-DRIVE -> all outputs return to reset values immediately; done stays 0; the next start runs a full run.
